// File: rtl/swin_lbuf_ctrl.sv
// Line-buffer sequencer for a 3-line sliding window.
// Tracks column/row of the incoming word stream and rotates three line BRAMs:
// one is written while the other two are read as the two previous rows.
// Read-row selects and the window valid are aligned two cycles after the
// accepted word, which matches the one-cycle read-first BRAM latency.
module swin_lbuf_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int ROW_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   cfg_line_words,
    input  logic [ROW_WIDTH-1:0]  cfg_lines,
    input  logic                  start,
    input  logic                  data_in_vld,
    output logic [2:0]            bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [1:0]            sel_line0,
    output logic [1:0]            sel_line1,
    output logic                  data_out_vld,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  cfg_err,
    output logic                  drop_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   col_reg, col_next;
    logic [ROW_WIDTH-1:0]    row_reg, row_next;
    logic [1:0]              wr_sel_reg, wr_sel_next;
    logic [ADDR_WIDTH-1:0]   lw_last_reg, lw_last_next;
    logic [ROW_WIDTH-1:0]    lines_last_reg, lines_last_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [2:0]              we_reg, we_next;
    logic                    s1_vld_reg, s1_vld_next;
    logic [1:0]              s1_sel0_reg, s1_sel0_next;
    logic [1:0]              s1_sel1_reg, s1_sel1_next;
    logic                    vld_reg;
    logic [1:0]              sel0_reg, sel1_reg;
    logic                    done_reg, done_next;
    logic                    cfg_err_reg, cfg_err_next;
    logic                    drop_err_reg, drop_err_next;

    logic                    accept;
    logic                    col_wrap;
    logic                    cfg_ok;

    assign accept   = (state_reg == ST_RUN) && data_in_vld;
    assign col_wrap = (col_reg == lw_last_reg);
    assign cfg_ok   = (cfg_line_words != '0) && (cfg_line_words <= MAX_WORDS)
                      && (cfg_lines != '0);

    // One-hot write enable: the BRAM currently selected for writing gets the word.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_we
            assign we_next[gi] = accept && (wr_sel_reg == 2'(gi));
        end
    endgenerate

    // Next-state, position counters and the first pipeline stage.
    always_comb begin
        state_next      = state_reg;
        col_next        = col_reg;
        row_next        = row_reg;
        wr_sel_next     = wr_sel_reg;
        lw_last_next    = lw_last_reg;
        lines_last_next = lines_last_reg;
        addr_next       = addr_reg;
        s1_vld_next     = 1'b0;
        cfg_err_next    = 1'b0;
        drop_err_next   = 1'b0;
        done_next       = (state_reg == ST_DONE);
        // Oldest row is the BRAM written next; middle row the one after that.
        case (wr_sel_reg)
            2'd0:    begin s1_sel0_next = 2'd1; s1_sel1_next = 2'd2; end
            2'd1:    begin s1_sel0_next = 2'd2; s1_sel1_next = 2'd0; end
            default: begin s1_sel0_next = 2'd0; s1_sel1_next = 2'd1; end
        endcase
        case (state_reg)
            ST_IDLE: begin
                drop_err_next = data_in_vld;
                if (start) begin
                    if (cfg_ok) begin
                        state_next      = ST_RUN;
                        // Low bits minus one is correct modulo 2^ADDR_WIDTH,
                        // including the full-length line.
                        lw_last_next    = cfg_line_words[ADDR_WIDTH-1:0]
                                          - ADDR_WIDTH'(1);
                        lines_last_next = cfg_lines - ROW_WIDTH'(1);
                        col_next        = '0;
                        row_next        = '0;
                        wr_sel_next     = 2'd0;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (data_in_vld) begin
                    addr_next   = col_reg;
                    s1_vld_next = (row_reg >= ROW_WIDTH'(2));
                    if (col_wrap) begin
                        col_next    = '0;
                        row_next    = row_reg + ROW_WIDTH'(1);
                        wr_sel_next = (wr_sel_reg == 2'd2) ? 2'd0 : wr_sel_reg + 2'd1;
                        if (row_reg == lines_last_reg) begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        col_next = col_reg + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                drop_err_next = data_in_vld;
                state_next    = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counters, config latches and the output pipeline; the last stage drains
    // independently of the FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg        <= '0;
            row_reg        <= '0;
            wr_sel_reg     <= '0;
            lw_last_reg    <= '0;
            lines_last_reg <= '0;
            addr_reg       <= '0;
            we_reg         <= '0;
            s1_vld_reg     <= 1'b0;
            s1_sel0_reg    <= '0;
            s1_sel1_reg    <= '0;
            vld_reg        <= 1'b0;
            sel0_reg       <= '0;
            sel1_reg       <= '0;
            done_reg       <= 1'b0;
            cfg_err_reg    <= 1'b0;
            drop_err_reg   <= 1'b0;
        end else begin
            col_reg        <= col_next;
            row_reg        <= row_next;
            wr_sel_reg     <= wr_sel_next;
            lw_last_reg    <= lw_last_next;
            lines_last_reg <= lines_last_next;
            addr_reg       <= addr_next;
            we_reg         <= we_next;
            s1_vld_reg     <= s1_vld_next;
            s1_sel0_reg    <= s1_sel0_next;
            s1_sel1_reg    <= s1_sel1_next;
            vld_reg        <= s1_vld_reg;
            if (s1_vld_reg) begin
                sel0_reg <= s1_sel0_reg;
                sel1_reg <= s1_sel1_reg;
            end
            done_reg       <= done_next;
            cfg_err_reg    <= cfg_err_next;
            drop_err_reg   <= drop_err_next;
        end
    end

    assign bram_we      = we_reg;
    assign bram_addr    = addr_reg;
    assign sel_line0    = sel0_reg;
    assign sel_line1    = sel1_reg;
    assign data_out_vld = vld_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign frame_done   = done_reg;
    assign cfg_err      = cfg_err_reg;
    assign drop_err     = drop_err_reg;

endmodule

// File: tb/tb_swin_lbuf_ctrl.sv
// Bench for swin_lbuf_ctrl. Expected outputs come from word-index arithmetic:
// word k of a frame has row k/line_words, col k%line_words, writes BRAM row%3,
// and (for row>=2) yields a window valid two cycles later.
module tb_swin_lbuf_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  cfg_line_words;
    logic [10:0] cfg_lines;
    logic        start;
    logic        data_in_vld;
    logic [2:0]  bram_we;
    logic [8:0]  bram_addr;
    logic [1:0]  sel_line0;
    logic [1:0]  sel_line1;
    logic        data_out_vld;
    logic        busy;
    logic        frame_done;
    logic        cfg_err;
    logic        drop_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Held-value model for outputs that keep their value between events.
    logic [8:0] m_addr = '0;
    logic [1:0] m_s0   = '0;
    logic [1:0] m_s1   = '0;

    int         obs_vld_cnt;
    int         obs_we_cnt;
    logic [1:0] obs_s0_q[$];
    logic [1:0] obs_s1_q[$];

    swin_lbuf_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_line_words (cfg_line_words),
        .cfg_lines      (cfg_lines),
        .start          (start),
        .data_in_vld    (data_in_vld),
        .bram_we        (bram_we),
        .bram_addr      (bram_addr),
        .sel_line0      (sel_line0),
        .sel_line1      (sel_line1),
        .data_out_vld   (data_out_vld),
        .busy           (busy),
        .frame_done     (frame_done),
        .cfg_err        (cfg_err),
        .drop_err       (drop_err)
    );

    always #5 clk = ~clk;

    // Runs one frame. mode: 0 continuous, 1 alternating 1/0, 2 random.
    // abort_at>0 stops after that many words (frame left running).
    // inj_start pulses start with junk config while words are still due.
    task automatic run_frame(input int lw, input int lines, input int mode,
                             input int abort_at, input bit inj_start);
        logic [2:0] e_we   [int];
        logic [8:0] e_addr [int];
        logic [1:0] e_s0   [int];
        logic [1:0] e_s1   [int];
        int   total, sent, c, last_c, row, col, i, exp_cnt;
        logic [2:0] we_exp;
        logic vld_exp, done_exp, busy_exp;
        bit   v;
        total  = lw * lines;
        sent   = 0;
        last_c = -10;
        obs_vld_cnt = 0;
        obs_we_cnt  = 0;
        obs_s0_q.delete();
        obs_s1_q.delete();
        cfg_line_words = 10'(lw);
        cfg_lines      = 11'(lines);
        start          = 1'b1;
        data_in_vld    = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy lw=%0d lines=%0d got=%b exp=1", lw, lines, busy);
        end
        c = 0;
        while (1) begin
            v = 1'b0;
            if (sent < total && (abort_at == 0 || sent < abort_at)) begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (c % 2 == 0);
                    default: v = ($urandom_range(0, 1) == 1);
                endcase
            end
            if (inj_start && sent < total && (c % 50) == 25) begin
                start          = 1'b1;
                cfg_lines      = '0;
                cfg_line_words = 10'($urandom_range(0, 1023));
            end else begin
                start = 1'b0;
            end
            data_in_vld = v;
            if (v) begin
                row = sent / lw;
                col = sent % lw;
                e_we[c+1]   = 3'(1 << (row % 3));
                e_addr[c+1] = 9'(col);
                if (row >= 2) begin
                    e_s0[c+2] = 2'((row + 1) % 3);
                    e_s1[c+2] = 2'((row + 2) % 3);
                end
                if (sent == total - 1) last_c = c;
                sent++;
            end
            @(posedge clk); #1;
            i        = c + 1;
            we_exp   = e_we.exists(i) ? e_we[i] : 3'b000;
            if (e_addr.exists(i)) m_addr = e_addr[i];
            vld_exp  = e_s0.exists(i);
            if (vld_exp) begin
                m_s0 = e_s0[i];
                m_s1 = e_s1[i];
            end
            done_exp = (last_c >= 0) && (i == last_c + 2);
            busy_exp = !((last_c >= 0) && (i >= last_c + 2));
            n_checks++;
            if (bram_we !== we_exp) begin
                n_fail++;
                $display("FAIL bram_we cyc=%0d got=%b exp=%b", i, bram_we, we_exp);
            end
            n_checks++;
            if (bram_addr !== m_addr) begin
                n_fail++;
                $display("FAIL bram_addr cyc=%0d got=%0d exp=%0d", i, bram_addr, m_addr);
            end
            n_checks++;
            if (data_out_vld !== vld_exp) begin
                n_fail++;
                $display("FAIL data_out_vld cyc=%0d got=%b exp=%b", i, data_out_vld, vld_exp);
            end
            n_checks++;
            if (sel_line0 !== m_s0 || sel_line1 !== m_s1) begin
                n_fail++;
                $display("FAIL sel cyc=%0d got=%0d,%0d exp=%0d,%0d", i, sel_line0, sel_line1, m_s0, m_s1);
            end
            n_checks++;
            if (frame_done !== done_exp) begin
                n_fail++;
                $display("FAIL frame_done cyc=%0d got=%b exp=%b", i, frame_done, done_exp);
            end
            n_checks++;
            if (busy !== busy_exp) begin
                n_fail++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", i, busy, busy_exp);
            end
            n_checks++;
            if (cfg_err !== 1'b0 || drop_err !== 1'b0) begin
                n_fail++;
                $display("FAIL err_flags cyc=%0d got cfg_err=%b drop_err=%b exp=0,0", i, cfg_err, drop_err);
            end
            if (data_out_vld === 1'b1) begin
                obs_vld_cnt++;
                obs_s0_q.push_back(sel_line0);
                obs_s1_q.push_back(sel_line1);
            end
            if (bram_we !== 3'b000) obs_we_cnt++;
            c++;
            if (abort_at > 0 && sent == abort_at) break;
            if (last_c >= 0 && c > last_c + 3) break;
            if (c > 20000) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_timeout lw=%0d lines=%0d cycles=%0d exp=frame end", lw, lines, c);
                break;
            end
        end
        data_in_vld = 1'b0;
        start       = 1'b0;
        if (abort_at == 0) begin
            exp_cnt = (lines >= 3) ? lw * (lines - 2) : 0;
            n_checks++;
            if (obs_vld_cnt != exp_cnt) begin
                n_fail++;
                $display("FAIL vld_count lw=%0d lines=%0d got=%0d exp=%0d", lw, lines, obs_vld_cnt, exp_cnt);
            end
            n_checks++;
            if (obs_we_cnt != total) begin
                n_fail++;
                $display("FAIL we_count lw=%0d lines=%0d got=%0d exp=%0d", lw, lines, obs_we_cnt, total);
            end
        end
        $display("frame lw=%0d lines=%0d mode=%0d words=%0d valids=%0d writes=%0d cycles=%0d",
                 lw, lines, mode, sent, obs_vld_cnt, obs_we_cnt, c);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        data_in_vld = 1'b0;
        cfg_line_words = '0;
        cfg_lines = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bram_we, bram_addr, sel_line0, sel_line1, data_out_vld, busy,
             frame_done, cfg_err, drop_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got we=%b addr=%0d s0=%0d s1=%0d vld=%b busy=%b done=%b ce=%b de=%b exp=all 0",
                     bram_we, bram_addr, sel_line0, sel_line1, data_out_vld, busy, frame_done, cfg_err, drop_err);
        end
        rst = 1'b0;
        $display("reset: outputs we=%b addr=%0d busy=%b", bram_we, bram_addr, busy);
    endtask

    task automatic test_reset_mid();
        run_frame(8, 6, 0, 28, 1'b0);
        // Reset together with a word and a start: reset must win.
        rst = 1'b1;
        data_in_vld = 1'b1;
        start = 1'b1;
        cfg_line_words = 10'd8;
        cfg_lines = 11'd6;
        @(posedge clk); #1;
        n_checks++;
        if ({bram_we, bram_addr, sel_line0, sel_line1, data_out_vld, busy,
             frame_done, cfg_err, drop_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got we=%b addr=%0d s0=%0d s1=%0d vld=%b busy=%b done=%b ce=%b de=%b exp=all 0",
                     bram_we, bram_addr, sel_line0, sel_line1, data_out_vld, busy, frame_done, cfg_err, drop_err);
        end
        rst = 1'b0;
        data_in_vld = 1'b0;
        start = 1'b0;
        m_addr = '0;
        m_s0 = '0;
        m_s1 = '0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || data_out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle got busy=%b vld=%b exp=0,0", busy, data_out_vld);
        end
        $display("reset_mid: abandoned frame at word 28, restarting");
        run_frame(8, 6, 0, 0, 1'b0);
    endtask

    task automatic test_nominal();
        run_frame(32, 16, 0, 0, 1'b0);
        n_checks++;
        if (obs_s0_q.size() == 0 || obs_s0_q[0] !== 2'd0 || obs_s1_q[0] !== 2'd1) begin
            n_fail++;
            $display("FAIL nominal_first_sel got n=%0d exp first sel=0,1", obs_s0_q.size());
        end
    endtask

    task automatic test_gapped();
        run_frame(32, 16, 1, 0, 1'b1);
    endtask

    task automatic test_boundary();
        logic [1:0] exp0 [3];
        logic [1:0] exp1 [3];
        exp0 = '{2'd0, 2'd1, 2'd2};
        exp1 = '{2'd1, 2'd2, 2'd0};
        run_frame(512, 3, 0, 0, 1'b0);
        run_frame(1, 5, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_s0_q.size() <= k) begin
                n_fail++;
                $display("FAIL lw1_sel%0d missing valid got count=%0d exp=3", k, obs_s0_q.size());
            end else if (obs_s0_q[k] !== exp0[k] || obs_s1_q[k] !== exp1[k]) begin
                n_fail++;
                $display("FAIL lw1_sel%0d got=%0d,%0d exp=%0d,%0d", k, obs_s0_q[k], obs_s1_q[k], exp0[k], exp1[k]);
            end
        end
    endtask

    task automatic test_errors();
        int lw_tab [3];
        int ln_tab [3];
        lw_tab = '{8, 513, 0};
        ln_tab = '{0, 4, 4};
        for (int k = 0; k < 3; k++) begin
            cfg_line_words = 10'(lw_tab[k]);
            cfg_lines = 11'(ln_tab[k]);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n_checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_err_pulse lw=%0d lines=%0d got cfg_err=%b busy=%b exp=1,0",
                         lw_tab[k], ln_tab[k], cfg_err, busy);
            end
            @(posedge clk); #1;
            n_checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_err_clear lw=%0d lines=%0d got cfg_err=%b busy=%b exp=0,0",
                         lw_tab[k], ln_tab[k], cfg_err, busy);
            end
            $display("cfg_check lw=%0d lines=%0d cfg_err seen", lw_tab[k], ln_tab[k]);
        end
        data_in_vld = 1'b1;
        @(posedge clk); #1;
        data_in_vld = 1'b0;
        n_checks++;
        if (drop_err !== 1'b1 || bram_we !== 3'b000 || bram_addr !== m_addr) begin
            n_fail++;
            $display("FAIL idle_drop got drop_err=%b we=%b addr=%0d exp=1,000,%0d", drop_err, bram_we, bram_addr, m_addr);
        end
        @(posedge clk); #1;
        n_checks++;
        if (drop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_drop_clear got=%b exp=0", drop_err);
        end
        $display("idle_drop: word in IDLE ignored");
    endtask

    task automatic test_short();
        run_frame(8, 2, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            run_frame($urandom_range(1, 40), $urandom_range(1, 7), 2, 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_nominal();
        test_gapped();
        test_boundary();
        test_errors();
        test_short();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
